// File: rtl/vec_packer_pkg.sv
// Shared definitions for the packer and the F-path blocks: collector state
// encoding and the lane slice helper.
package vec_packer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DISCARD = 1'b1
  } pack_state_e;

  // Low bit of element lane k in a vector of dw-bit elements.
  function automatic int unsigned lane_lo(input int unsigned k, input int unsigned dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/vec_frame_buf.sv
// One J-lane frame register with a full flag. A lane write can clear every
// lane above it so a short frame lands zero-padded.
module vec_frame_buf
  import vec_packer_pkg::*;
#(
  parameter int unsigned J         = 14,
  parameter int unsigned DATAWIDTH = 64,
  localparam int unsigned J_WIDTH  = $clog2(J)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [J_WIDTH-1:0]     wr_idx,
  input  logic [DATAWIDTH-1:0]   wr_data,
  input  logic                   zero_fill,
  input  logic                   set_full,
  input  logic                   clr_full,
  output logic [J*DATAWIDTH-1:0] data,
  output logic                   full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (wr_en) begin
        for (int unsigned k = 0; k < J; k++) begin
          if (J_WIDTH'(k) == wr_idx)
            data[lane_lo(k, DATAWIDTH) +: DATAWIDTH] <= wr_data;
          else if (zero_fill && (J_WIDTH'(k) > wr_idx))
            data[lane_lo(k, DATAWIDTH) +: DATAWIDTH] <= '0;
        end
      end
      if (set_full)
        full <= 1'b1;
      else if (clr_full)
        full <= 1'b0;
    end
  end

endmodule

// File: rtl/vec_packer.sv
// Serial-to-wide packer: J stream elements per s_tlast-framed frame into one
// J*DATAWIDTH vector, through two ping-pong frame buffers.
module vec_packer
  import vec_packer_pkg::*;
#(
  parameter int unsigned J         = 14,
  parameter int unsigned DATAWIDTH = 64,
  localparam int unsigned J_WIDTH  = $clog2(J)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATAWIDTH-1:0]   s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [J*DATAWIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   err_short,
  output logic                   err_long
);

  pack_state_e            state;
  logic [J_WIDTH-1:0]     idx;
  logic                   wr_sel;
  logic                   rd_sel;
  logic [J*DATAWIDTH-1:0] buf_data [2];
  logic [1:0]             buf_full;

  logic in_beat;
  logic collect_beat;
  logic last_lane;
  logic frame_done;
  logic out_fire;

  assign s_tready     = ~rst & ((state == DISCARD) | ~buf_full[wr_sel]);
  assign in_beat      = s_tvalid & s_tready;
  assign collect_beat = in_beat & (state == COLLECT);
  assign last_lane    = (idx == J_WIDTH'(J - 1));
  assign frame_done   = collect_beat & (s_tlast | last_lane);

  assign m_tvalid = buf_full[rd_sel];
  assign m_tdata  = buf_data[rd_sel];
  assign out_fire = m_tvalid & m_tready;

  for (genvar b = 0; b < 2; b++) begin : g_buf
    vec_frame_buf #(
      .J         (J),
      .DATAWIDTH (DATAWIDTH)
    ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (collect_beat & (wr_sel == 1'(b))),
      .wr_idx    (idx),
      .wr_data   (s_tdata),
      .zero_fill (s_tlast),
      .set_full  (frame_done & (wr_sel == 1'(b))),
      .clr_full  (out_fire & (rd_sel == 1'(b))),
      .data      (buf_data[b]),
      .full      (buf_full[b])
    );
  end

  // Frame collector: lane index, buffer selects, DISCARD after a long frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      idx       <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      if (in_beat) begin
        unique case (state)
          COLLECT: begin
            if (s_tlast || last_lane) begin
              idx    <= '0;
              wr_sel <= ~wr_sel;
              if (s_tlast && !last_lane)
                err_short <= 1'b1;
              if (!s_tlast && last_lane) begin
                err_long <= 1'b1;
                state    <= DISCARD;
              end
            end else begin
              idx <= idx + J_WIDTH'(1);
            end
          end
          DISCARD: begin
            if (s_tlast)
              state <= COLLECT;
          end
          default: state <= COLLECT;
        endcase
      end
      if (out_fire)
        rd_sel <= ~rd_sel;
    end
  end

endmodule
